// File: rtl/aes_decrypt_sched.sv
// aes_decrypt_sched: round-robin request scheduler, tag tracker and credit-protected result FIFO for the pipelined aes_decrypt core
//   clk, rst (sync, active-high)
//   req_valid/req_ready/req_ct : NREQ requesters, one-hot grant, ciphertext i at [128*i +: 128]
//   key_wr/key_in/key_ready    : key change, accepted only once the core pipeline is empty
//   core_load/core_ct/core_key : registered issue to the core
//   core_pt_valid/core_pt      : core result, LAT = Nr+2 cycles after core_load
//   rsp_valid/rsp_ready/rsp_pt/rsp_id : in-order plaintext responses from the FIFO head
//   err                        : sticky tag/result mismatch
//   AES_DEC_SCHED_RR_EN defined selects round-robin; undefined selects fixed priority (lowest index)
module aes_decrypt_sched #(
    parameter int NREQ  = 4,
    parameter int Nk    = 4,
    parameter int Nr    = Nk + 6,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [128*NREQ-1:0]     req_ct,
    input  logic                    key_wr,
    input  logic [32*Nk-1:0]        key_in,
    output logic                    key_ready,
    output logic                    core_load,
    output logic [127:0]            core_ct,
    output logic [32*Nk-1:0]        core_key,
    input  logic                    core_pt_valid,
    input  logic [127:0]            core_pt,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [127:0]            rsp_pt,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic                    err
);
    localparam int LAT = Nr + 2;
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {RUN, DRAIN} state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr, off, gnt_id;
    logic [IDW:0]     sum;
    logic [NREQ-1:0]  rot;
    logic             gnt_any, issue_ok, hs, tv, push, pop;
    logic [CW:0]      credit_used;
    logic [CW-1:0]    inflight_q, inflight_d, fifo_cnt_q;
    logic [IDW:0]     tag_q [LAT+1];
    logic [127:0]     fifo_pt [DEPTH];
    logic [IDW-1:0]   fifo_id [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic             core_load_q, err_q;
    logic [127:0]     core_ct_q;
    logic [32*Nk-1:0] core_key_q;

`ifdef AES_DEC_SCHED_RR_EN
    logic [IDW-1:0] rr_q;
    assign rr = rr_q;
    always_ff @(posedge clk) begin
        if (rst) rr_q <= '0;
        else if (hs) rr_q <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end
`else
    assign rr = '0;
`endif

    // Rotate the request vector so bit 0 is the requester at the pointer, pick the
    // lowest set bit, then rotate the offset back into a requester index.
    always_comb begin
        rot     = NREQ'({req_valid, req_valid} >> rr);
        gnt_any = |req_valid;
        off     = '0;
        for (int k = NREQ - 1; k >= 0; k--) off = rot[k] ? IDW'(k) : off;
        sum     = {1'b0, rr} + {1'b0, off};
        gnt_id  = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : IDW'(sum);
    end

    // FIFO occupancy ignores a same-cycle pop so a result can never find the FIFO full.
    assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
    assign issue_ok    = (state_q == RUN) && !key_wr && (credit_used < (CW+1)'(DEPTH));
    assign hs          = issue_ok && gnt_any;
    assign req_ready   = hs ? (NREQ'(1) << gnt_id) : '0;

    assign tv         = tag_q[LAT][IDW];
    assign push       = core_pt_valid && tv;
    assign inflight_d = inflight_q + CW'(hs) - CW'(tv);

    assign rsp_valid = fifo_cnt_q != '0;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_pt    = rsp_valid ? fifo_pt[rd_ptr_q] : '0;
    assign rsp_id    = rsp_valid ? fifo_id[rd_ptr_q] : '0;

    always_comb begin
        key_ready = (inflight_q == '0) && (state_q == DRAIN || key_wr);
        state_d   = key_ready ? RUN : ((key_wr || state_q == DRAIN) ? DRAIN : RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            inflight_q  <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            core_load_q <= 1'b0;
            core_ct_q   <= '0;
            core_key_q  <= '0;
            err_q       <= 1'b0;
            for (int k = 0; k <= LAT; k++) tag_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            inflight_q  <= inflight_d;
            fifo_cnt_q  <= fifo_cnt_q + CW'(push) - CW'(pop);
            wr_ptr_q    <= push ? ((wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
            rd_ptr_q    <= pop ? ((rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
            core_load_q <= hs;
            core_ct_q   <= hs ? req_ct[128*gnt_id +: 128] : core_ct_q;
            core_key_q  <= key_ready ? key_in : core_key_q;
            err_q       <= err_q || (core_pt_valid != tv);
            tag_q[0]    <= {hs, gnt_id};
            for (int k = 1; k <= LAT; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pt[wr_ptr_q] <= core_pt;
            fifo_id[wr_ptr_q] <= tag_q[LAT][IDW-1:0];
        end
    end

    assign core_load = core_load_q;
    assign core_ct   = core_ct_q;
    assign core_key  = core_key_q;
    assign err       = err_q;
endmodule

// File: tb/tb_aes_decrypt_sched.sv
// tb_aes_decrypt_sched: scoreboard bench for aes_decrypt_sched with a delay-line core model
module tb_aes_decrypt_sched;
    localparam int NREQ  = 4;
    localparam int NK    = 4;
    localparam int DEPTH = 6;
    localparam int LAT   = NK + 8;
    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

    typedef struct packed {logic [127:0] pt; logic [1:0] id;} exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [128*NREQ-1:0]  req_ct;
    logic                 key_wr = 1'b0;
    logic [32*NK-1:0]     key_in = '0;
    logic                 key_ready, core_load, core_pt_valid, rsp_valid, err;
    logic                 rsp_ready = 1'b1;
    logic                 inj = 1'b0;
    logic [127:0]         core_ct, core_pt, rsp_pt;
    logic [32*NK-1:0]     core_key;
    logic [1:0]           rsp_id;

    int tests = 0, fails = 0, cyc = 0;
    int hs_cnt = 0, rsp_cnt = 0, kr_cnt = 0, hs_cyc = 0, rsp_cyc = 0, kr_cyc = 0;
    int rr_m = 0, g = 0;
    int n0, n1, k0;
    logic [127:0] cur_key = '0;
    exp_t exp_q[$];
    exp_t e_in, e_out;

    aes_decrypt_sched #(.NREQ(NREQ), .Nk(NK), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_ct(req_ct),
        .key_wr(key_wr), .key_in(key_in), .key_ready(key_ready),
        .core_load(core_load), .core_ct(core_ct), .core_key(core_key),
        .core_pt_valid(core_pt_valid), .core_pt(core_pt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_pt(rsp_pt), .rsp_id(rsp_id), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core stand-in: known FIPS-197 vector, otherwise a key-dependent scramble.
    function automatic logic [127:0] dec(input logic [127:0] c, input logic [127:0] k);
        return (c == CT && k == K0) ? PT : c ^ k ^ {4{32'hdeadbeef}};
    endfunction

    logic [LAT-1:0] pv;
    logic [127:0]   pd [LAT];
    always @(posedge clk) begin
        pv    <= rst ? '0 : {pv[LAT-2:0], core_load};
        pd[0] <= dec(core_ct, core_key);
        for (int k = 1; k < LAT; k++) pd[k] <= pd[k-1];
    end
    assign core_pt_valid = pv[LAT-1] | inj;
    assign core_pt       = pd[LAT-1];

    for (genvar i = 0; i < NREQ; i++) begin : g_ct
        assign req_ct[128*i +: 128] = (i == 2) ? CT : CT ^ 128'(i + 1);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_hs(input int target, input int budget);
        for (int b = 0; b < budget && hs_cnt < target; b++) tick(1);
        chk("handshake wait", 128'(hs_cnt >= target), 128'(1));
    endtask

    task automatic wait_rsp(input int target, input int budget);
        for (int b = 0; b < budget && rsp_cnt < target; b++) tick(1);
        chk("response wait", 128'(rsp_cnt >= target), 128'(1));
    endtask

    task automatic key_load(input logic [127:0] k);
        key_in = k;
        key_wr = 1'b1;
        @(negedge clk);
        chk("idle key_ready", 128'(key_ready), 128'(1));
        tick(1);
        key_wr = 1'b0;
        chk("core_key loaded", core_key, k);
    endtask

    task automatic reset_checks(input string nm);
        @(negedge clk);
        chk({nm, " req_ready"}, 128'(req_ready), 128'(0));
        chk({nm, " core_load"}, 128'(core_load), 128'(0));
        chk({nm, " core_ct"}, core_ct, 128'(0));
        chk({nm, " core_key"}, core_key, 128'(0));
        chk({nm, " key_ready"}, 128'(key_ready), 128'(0));
        chk({nm, " rsp_valid"}, 128'(rsp_valid), 128'(0));
        chk({nm, " rsp_pt"}, rsp_pt, 128'(0));
        chk({nm, " rsp_id"}, 128'(rsp_id), 128'(0));
        chk({nm, " err"}, 128'(err), 128'(0));
    endtask

    // Issue side: check the grant against the arbitration model and push the expected response.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            rr_m    = 0;
            cur_key = '0;
        end else begin
            if (key_ready) begin
                kr_cnt++;
                kr_cyc  = cyc;
                cur_key = key_in;
            end
            if (req_ready != '0) begin
                g = -1;
                for (int k = 0; k < NREQ; k++)
                    if (g < 0 && req_valid[(rr_m + k) % NREQ]) g = (rr_m + k) % NREQ;
                chk("grant", 128'(req_ready), (g < 0) ? 128'(0) : 128'(1) << g);
                if (g >= 0) begin
                    e_in.pt = dec(req_ct[128*g +: 128], cur_key);
                    e_in.id = 2'(g);
                    exp_q.push_back(e_in);
                    hs_cnt++;
                    hs_cyc = cyc;
`ifdef AES_DEC_SCHED_RR_EN
                    rr_m = (g + 1) % NREQ;
`endif
                end
            end
        end
    end

    // Response side: every popped response must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected response: got pt %h id %0d, expected none", rsp_pt, rsp_id);
            end else begin
                e_out = exp_q.pop_front();
                chk("rsp_pt", rsp_pt, e_out.pt);
                chk("rsp_id", 128'(rsp_id), 128'(e_out.id));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick(3);
        rst = 1'b0;
        reset_checks("reset");
        tick(1);
        key_load(K0);

        // single request from requester 2
        req_valid = 4'b0100;
        wait_hs(1, 10);
        req_valid = '0;
        wait_rsp(1, 30);
        chk("handshake to rsp latency", 128'(rsp_cyc - hs_cyc), 128'(14));

        // all requesters valid for 16 cycles
        req_valid = '1;
        tick(16);
        req_valid = '0;
        wait_rsp(hs_cnt, 60);

        // backpressure
        rsp_ready = 1'b0;
        n0 = hs_cnt;
        req_valid = '1;
        tick(25);
        chk("backpressure handshakes", 128'(hs_cnt - n0), 128'(DEPTH));
        @(negedge clk);
        chk("backpressure req_ready", 128'(req_ready), 128'(0));
        chk("backpressure rsp_valid", 128'(rsp_valid), 128'(1));
        tick(1);
        rsp_ready = 1'b1;
        wait_hs(n0 + DEPTH + 1, 10);
        req_valid = '0;
        wait_rsp(hs_cnt, 60);
        chk("backpressure err", 128'(err), 128'(0));

        // key change with 5 blocks in flight
        n0 = hs_cnt;
        req_valid = 4'b0100;
        wait_hs(n0 + 5, 20);
        key_in = K1;
        key_wr = 1'b1;
        k0 = kr_cnt;
        n1 = hs_cnt;
        for (int b = 0; b < 40 && kr_cnt == k0; b++) tick(1);
        key_wr = 1'b0;
        chk("no grant while draining", 128'(hs_cnt), 128'(n1));
        chk("key_ready after drain", 128'(kr_cyc - hs_cyc), 128'(14));
        chk("new core_key", core_key, K1);
        wait_hs(n1 + 1, 5);
        req_valid = '0;
        wait_rsp(hs_cnt, 60);
        tick(3);
        chk("key_ready pulses", 128'(kr_cnt - k0), 128'(1));

        // reset with 6 blocks in flight
        n0 = hs_cnt;
        req_valid = '1;
        wait_hs(n0 + 6, 20);
        req_valid = '0;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        reset_checks("mid-burst reset");
        k0 = rsp_cnt;
        tick(25);
        chk("no responses after reset", 128'(rsp_cnt), 128'(k0));
        chk("err after reset", 128'(err), 128'(0));
        key_load(K0);

        // spurious result with no tag
        inj = 1'b1;
        tick(1);
        inj = 1'b0;
        @(negedge clk);
        chk("spurious err", 128'(err), 128'(1));
        chk("spurious fifo", 128'(rsp_valid), 128'(0));
        tick(5);
        chk("err sticky", 128'(err), 128'(1));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("err cleared", 128'(err), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
